// File: rtl/arith_arb.sv
//==============================================================================
// Module   : arith_arb
// Brief    : Round-robin arbiter/sequencer for a shared ARITH add/sub unit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module arith_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             afn0,
    input  logic             afn1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res,
    output logic             rz,
    output logic             rv,
    output logic             rn,
    output logic             owner,
    output logic             busy,
    output logic [WIDTH-1:0] arith_a,
    output logic [WIDTH-1:0] arith_b,
    output logic             arith_afn,
    input  logic [WIDTH-1:0] arith_s,
    input  logic             arith_z,
    input  logic             arith_v,
    input  logic             arith_n
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_ptr;
    logic             r_gsel;
    logic             w_grant;
    logic             w_win;
    logic [WIDTH-1:0] r_arith_a;
    logic [WIDTH-1:0] r_arith_b;
    logic             r_arith_afn;
    logic [WIDTH-1:0] r_res;
    logic             r_rz;
    logic             r_rv;
    logic             r_rn;
    logic             r_owner;

    // Contention goes to the pointer; a lone requester simply wins.
    assign w_grant = (r_state == c_S_IDLE) && (req0 || req1);
    assign w_win   = (req0 && req1) ? r_ptr : req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (req0 || req1) w_state_nxt = c_S_EXEC;
            c_S_EXEC: w_state_nxt = c_S_DONE;
            c_S_DONE: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        done0 = 1'b0;
        done1 = 1'b0;
        busy  = (r_state != c_S_IDLE);
        if (r_state == c_S_DONE) begin
            done0 = ~r_gsel;
            done1 = r_gsel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= 1'b0;
            r_gsel      <= 1'b0;
            r_arith_a   <= '0;
            r_arith_b   <= '0;
            r_arith_afn <= 1'b0;
        end else if (w_grant) begin
            r_ptr       <= ~w_win;
            r_gsel      <= w_win;
            r_arith_a   <= w_win ? a1 : a0;
            r_arith_b   <= w_win ? b1 : b0;
            r_arith_afn <= w_win ? afn1 : afn0;
        end
    end

    // ARITH has had the whole EXEC cycle to settle from the registered operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res   <= '0;
            r_rz    <= 1'b0;
            r_rv    <= 1'b0;
            r_rn    <= 1'b0;
            r_owner <= 1'b0;
        end else if (r_state == c_S_EXEC) begin
            r_res   <= arith_s;
            r_rz    <= arith_z;
            r_rv    <= arith_v;
            r_rn    <= arith_n;
            r_owner <= r_gsel;
        end
    end

    assign arith_a   = r_arith_a;
    assign arith_b   = r_arith_b;
    assign arith_afn = r_arith_afn;
    assign res       = r_res;
    assign rz        = r_rz;
    assign rv        = r_rv;
    assign rn        = r_rn;
    assign owner     = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_arith_arb.sv
//==============================================================================
// Module   : tb_arith_arb
// Brief    : Scoreboard bench for arith_arb with a behavioural ARITH unit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_arith_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, afn0 = 1'b0, afn1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        done0, done1, rz, rv, rn, owner, busy, arith_afn;
    logic [31:0] res, arith_a, arith_b, arith_s;
    logic        arith_z, arith_v, arith_n;

    typedef struct {
        logic        own;
        logic [31:0] r;
        logic        z;
        logic        v;
        logic        n;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    arith_arb #(.WIDTH(32)) dut (
        .clk(clk), .reset(rst),
        .req0(req0), .req1(req1), .afn0(afn0), .afn1(afn1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .res(res),
        .rz(rz), .rv(rv), .rn(rn), .owner(owner), .busy(busy),
        .arith_a(arith_a), .arith_b(arith_b), .arith_afn(arith_afn),
        .arith_s(arith_s), .arith_z(arith_z), .arith_v(arith_v), .arith_n(arith_n)
    );

    // Behavioural ARITH unit
    assign arith_s = arith_afn ? (arith_a - arith_b) : (arith_a + arith_b);
    assign arith_z = (arith_s == 32'd0);
    assign arith_n = arith_s[31];
    assign arith_v = (arith_a[31] == (arith_b[31] ^ arith_afn)) && (arith_s[31] != arith_a[31]);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && (done0 || done1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {done1, done0}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done0", done0, !e.own);
                chk("done1", done1, e.own);
                chk("owner", owner, e.own);
                chk("res", res, e.r);
                chk("flags_zvn", {rz, rv, rn}, {e.z, e.v, e.n});
                chk("busy_in_done", busy, 1'b1);
            end
        end
    end

    task automatic push(input logic own, input logic [31:0] r, input logic z, v, n, input int at);
        exp_t e;
        e.own = own; e.r = r; e.z = z; e.v = v; e.n = n; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issue one lone request while IDLE; caller is at posedge+1.
    task automatic single(input logic cl, input logic afn, input logic [31:0] a, b,
                          input logic [31:0] er, input logic ez, ev, en);
        bit seen;
        seen = 0;
        if (cl) begin a1 = a; b1 = b; afn1 = afn; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; afn0 = afn; req0 = 1'b1; end
        push(cl, er, ez, ev, en, cyc + 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cl ? done1 : done0) begin seen = 1; break; end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL single_timeout: got no DONE%0d expected a pulse", cl);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int   c0;
        int   n0, n1;
        bit   stop;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {done0, done1, busy, rz, rv, rn, owner, arith_afn}, 64'd0);
        chk("reset_res", res, 32'd0);
        chk("reset_arith_ab", {arith_a, arith_b}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        single(1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
        single(1'b1, 1'b1, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0);
        single(1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        single(1'b0, 1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of EXEC
        a0 = 32'd10; b0 = 32'd20; afn0 = 1'b0; req0 = 1'b1;
        @(posedge clk); #1;
        chk("busy_in_exec", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {done0, done1, busy, rz, rv, rn, owner, arith_afn}, 64'd0);
        chk("midrst_res", res, 32'd0);
        chk("midrst_arith_ab", {arith_a, arith_b}, 64'd0);
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        single(1'b0, 1'b0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0);

        // Contention: both hold REQ, each loads a new op on its DONE
        do_reset();
        a0 = 32'd1;  b0 = 32'd2; afn0 = 1'b0;
        a1 = 32'd10; b1 = 32'd4; afn1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        c0 = cyc;
        push(1'b0, 32'd3,          1'b0, 1'b0, 1'b0, c0 + 2);
        push(1'b1, 32'd6,          1'b0, 1'b0, 1'b0, c0 + 5);
        push(1'b0, 32'd101,        1'b0, 1'b0, 1'b0, c0 + 8);
        push(1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1, c0 + 11);
        n0 = 0; n1 = 0; stop = 0;
        for (int i = 0; i < 30 && !stop; i++) begin
            @(negedge clk);
            if (done0) begin
                n0++;
                if (n0 == 1) begin a0 = 32'd100; b0 = 32'd1; afn0 = 1'b0; end
                else req0 = 1'b0;
            end
            if (done1) begin
                n1++;
                if (n1 == 1) begin a1 = 32'd0; b1 = 32'd1; afn1 = 1'b1; end
                else req1 = 1'b0;
            end
            if (n0 == 2 && n1 == 2) stop = 1;
        end
        chk("contention_done_counts", {n0[7:0], n1[7:0]}, {8'd2, 8'd2});
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;

        // Pending loser: REQ1 arrives while client 0 is in EXEC
        do_reset();
        a0 = 32'd2; b0 = 32'd2; afn0 = 1'b0; req0 = 1'b1;
        c0 = cyc;
        push(1'b0, 32'd4,         1'b0, 1'b0, 1'b0, c0 + 2);
        push(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, c0 + 5);
        @(posedge clk); #1;
        a1 = 32'd7; b1 = 32'd9; afn1 = 1'b1; req1 = 1'b1;
        n1 = 0;
        for (int i = 0; i < 12 && n1 == 0; i++) begin
            @(negedge clk);
            if (done0) req0 = 1'b0;
            if (done1) begin req1 = 1'b0; n1 = 1; end
        end
        chk("pending_done1_seen", n1, 1);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/arith_arb.md
# arith_arb

Two-requester arbiter and sequencer for the shared 32-bit ARITH add/subtract unit. It accepts operation requests from two clients, selects one with round-robin priority, and registers that client's operands into the ARITH inputs. It captures the ARITH sum and Z/V/N flags, then returns them to the winning client with a one-cycle DONE pulse. It sits between the ALU datapath clients (for example the main ALU path and an address/branch-compare path) and a single external ARITH instance.

## Interface
- WIDTH, 32: operand/result width; must equal the ARITH width (32).

- CLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ0 / REQ1  in  1  request from client 0 / 1.
- AFN0 / AFN1  in  1  operation for client 0 / 1: 0 = A+B, 1 = A−B.
- A0, B0 / A1, B1  in  WIDTH  operands for client 0 / 1. Stable while REQ is high.
- DONE0 / DONE1  out  1  one-cycle pulse: result for client 0 / 1 is valid.
- RES  out  WIDTH  captured ARITH sum; held until the next capture.
- RZ, RV, RN  out  1  captured zero, signed-overflow and negative flags; held with RES.
- OWNER  out  1  index of the client that owns RES and the flags.
- BUSY  out  1  high in any state other than IDLE.
- ARITH_A, ARITH_B  out  WIDTH  registered operands driven to ARITH.
- ARITH_AFN  out  1  registered function select driven to ARITH.
- ARITH_S  in  WIDTH  combinational sum from ARITH.
- ARITH_Z, ARITH_V, ARITH_N  in  1  combinational flags from ARITH.

## Operation
- FSM states are IDLE, EXEC and DONE.
- **IDLE**
  - No REQ high: stay in IDLE.
  - Exactly one REQ high: grant that client.
  - Both REQ high: grant the client selected by the priority pointer PTR.
  - On grant: latch the winner's A, B and AFN into ARITH_A/ARITH_B/ARITH_AFN, set GSEL to the winner, set PTR to the other client, go to EXEC.
- **EXEC**
  - ARITH settles from the registered operands.
  - At the clock edge, capture ARITH_S/Z/V/N into RES/RZ/RV/RN, set OWNER to GSEL, go to DONE.
- **DONE**
  - DONE[GSEL] = 1 for exactly this cycle; go to IDLE unconditionally.
- **PTR rules**
  - PTR changes only on a grant.
  - A lone requester still flips PTR to the other client, so after a lone grant to client 0, a subsequent simultaneous request favours client 1.
- **Client protocol**
  - A client holds REQ and its operands stable until it sees its DONE.
  - It deasserts REQ in the DONE cycle (sampled low at the following edge) or presents a new operation.
  - A REQ high in IDLE is always a new request.
  - A request from the losing client stays pending and is granted in the next IDLE cycle.
- **Flags** follow ARITH semantics:
  - Z = (S == 0).
  - N = S[31].
  - V = signed overflow: operand signs equal (for subtraction, A's sign equal to the inverted sign of B) and S's sign different from A's.
  - The block does not recompute the flags; it only registers them.
- **Reset** (any time, including mid-EXEC or mid-DONE)
  - State IDLE, PTR = 0.
  - ARITH_A = ARITH_B = 0, ARITH_AFN = 0.
  - RES = 0, RZ = RV = RN = 0, OWNER = 0.
  - DONE0 = DONE1 = 0, BUSY = 0.
  - An aborted operation never produces DONE; the client must re-request.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from REQ to DONE.
- Latency: REQ sampled high at edge k (state IDLE) → EXEC in cycle k+1 → DONE pulse and valid RES in cycle k+2.
- Throughput: one operation per 3 cycles. Back-to-back alternating requests are granted at edges k, k+3, k+6, ….
- BUSY is high in EXEC and DONE, and low in IDLE.
- RES/flags/OWNER change only on the EXEC→DONE edge or on reset.
- The combinational path ARITH_A/B/AFN → ARITH_S → RES register must fit in one CLK period.

## Test plan
- **Basic add:** after reset, REQ0=1, AFN0=0, A0=5, B0=7.
  - Required: DONE0 pulses 2 cycles after grant; RES=12, RZ=0, RV=0, RN=0, OWNER=0.
- **Zero result:** REQ1=1, AFN1=1, A1=3, B1=3.
  - Required: RES=0, RZ=1, RN=0, RV=0, OWNER=1; DONE1 pulses and DONE0 stays 0.
- **Overflow:** A0=0x7FFFFFFF, B0=1, add.
  - Required: RES=0x80000000, RV=1, RN=1.
  - Also: A0=0x80000000, B0=1, sub gives RES=0x7FFFFFFF, RV=1, RN=0.
- **Contention:** after reset, REQ0 and REQ1 both held high; each client re-requests immediately after its DONE.
  - Required: grants alternate 0,1,0,1; DONE0/DONE1 pulses are 3 cycles apart; neither client is starved.
- **Reset mid-operation:** assert RESET during EXEC of A0=10, B0=20.
  - Required: no DONE pulse; all outputs return to reset values immediately; after RESET drops, a new REQ0 completes normally with RES=30.
- **Pending loser:** REQ0 alone at cycle 0; REQ1 raised at cycle 1 and held.
  - Required: DONE0 in cycle 2; client 1 granted at the first IDLE edge after that; DONE1 in cycle 5.
